// File: rtl/sys_ctrl_if.sv
// Command-path bundle between sys_ctrl, the UART RX/TX datapaths and the register file.
// master = sys_ctrl side, slave = environment side; dbg_state mirrors the controller FSM state.
interface sys_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  // Handshakes: i_RX_D_VLD and i_RdData_Valid qualify their data for exactly the cycle they are
  // high; o_TX_D_VLD is a one-cycle pulse issued only in a cycle where i_TX_Busy was sampled low,
  // and o_TX_P_Data is held stable while a byte waits for the transmitter.
  logic [DATA_WIDTH-1:0]    i_RX_P_Data;
  logic                     i_RX_D_VLD;
  logic [DATA_WIDTH-1:0]    i_RdData;
  logic                     i_RdData_Valid;
  logic                     i_TX_Busy;
  logic [ADDRESS_WIDTH-1:0] o_Address;
  logic [DATA_WIDTH-1:0]    o_WrData;
  logic                     o_WrEn;
  logic                     o_RdEn;
  logic [DATA_WIDTH-1:0]    o_TX_P_Data;
  logic                     o_TX_D_VLD;
  logic                     o_Cmd_Err;
  logic                     o_Busy;
  logic [2:0]               dbg_state;

  modport master (
    input  i_RX_P_Data, i_RX_D_VLD, i_RdData, i_RdData_Valid, i_TX_Busy,
    output o_Address, o_WrData, o_WrEn, o_RdEn, o_TX_P_Data, o_TX_D_VLD, o_Cmd_Err, o_Busy,
    output dbg_state
  );

  modport slave (
    output i_RX_P_Data, i_RX_D_VLD, i_RdData, i_RdData_Valid, i_TX_Busy,
    input  o_Address, o_WrData, o_WrEn, o_RdEn, o_TX_P_Data, o_TX_D_VLD, o_Cmd_Err, o_Busy,
    input  dbg_state
  );
endinterface

// File: rtl/sys_ctrl.sv
// UART command controller: decodes 0xAA (write) / 0xBB (read) byte frames into register-file
// accesses and returns read data to the transmitter. SYS_CTRL_FRAME_TIMEOUT_EN adds an inter-byte timeout.
module sys_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int RD_TIMEOUT    = 4
) (
  input  logic      CLK,
  input  logic      RSTn,
  sys_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_TX_SEND = 3'd5
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
  localparam int                    TW     = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0]         RD_LAST = TW'(RD_TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    wrdata_q, wrdata_d;
  logic                     wren_q, wren_d;
  logic                     rden_q, rden_d;
  logic [DATA_WIDTH-1:0]    txdata_q, txdata_d;
  logic                     txvld_q, txvld_d;
  logic                     err_q, err_d;
  logic                     busy_q;
  logic [DATA_WIDTH-1:0]    hold_q, hold_d;
  logic [TW-1:0]            rd_timer_q, rd_timer_d;

  logic                     rx_vld;
  logic [DATA_WIDTH-1:0]    rx_byte;

  assign rx_vld  = bus.i_RX_D_VLD;
  assign rx_byte = bus.i_RX_P_Data;

`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
  logic [9:0] frame_cnt_q, frame_cnt_d;
  logic       in_frame;
  assign in_frame = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) || (state_q == S_RD_ADDR);
`endif

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    wrdata_d   = wrdata_q;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    txdata_d   = txdata_q;
    txvld_d    = 1'b0;
    err_d      = 1'b0;
    hold_d     = hold_q;
    rd_timer_d = rd_timer_q;
`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
    frame_cnt_d = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_vld) begin
          if (rx_byte == CMD_WR)      state_d = S_WR_ADDR;
          else if (rx_byte == CMD_RD) state_d = S_RD_ADDR;
          else                        err_d   = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (rx_vld) begin
          address_d = rx_byte[ADDRESS_WIDTH-1:0];
          state_d   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (rx_vld) begin
          wrdata_d = rx_byte;
          wren_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (rx_vld) begin
          address_d  = rx_byte[ADDRESS_WIDTH-1:0];
          rden_d     = 1'b1;
          rd_timer_d = '0;
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // A stray RX byte is flagged but does not abort the outstanding read.
        if (rx_vld) err_d = 1'b1;
        if (bus.i_RdData_Valid) begin
          hold_d     = bus.i_RdData;
          rd_timer_d = '0;
          state_d    = S_TX_SEND;
        end else if (rd_timer_q == RD_LAST) begin
          err_d      = 1'b1;
          rd_timer_d = '0;
          state_d    = S_IDLE;
        end else begin
          rd_timer_d = rd_timer_q + 1'b1;
        end
      end
      S_TX_SEND: begin
        if (rx_vld) err_d = 1'b1;
        if (!bus.i_TX_Busy) begin
          txdata_d = hold_q;
          txvld_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
    // Any received byte restarts the inter-byte window; expiry abandons the frame with no strobe.
    if (in_frame) begin
      if (rx_vld) begin
        frame_cnt_d = '0;
      end else if (frame_cnt_q == 10'd1023) begin
        err_d       = 1'b1;
        state_d     = S_IDLE;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 10'd1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      address_q  <= '0;
      wrdata_q   <= '0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
      txdata_q   <= '0;
      txvld_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      hold_q     <= '0;
      rd_timer_q <= '0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      wrdata_q   <= wrdata_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
      txdata_q   <= txdata_d;
      txvld_q    <= txvld_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
      hold_q     <= hold_d;
      rd_timer_q <= rd_timer_d;
    end
  end

`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`endif

  assign bus.o_Address   = address_q;
  assign bus.o_WrData    = wrdata_q;
  assign bus.o_WrEn      = wren_q;
  assign bus.o_RdEn      = rden_q;
  assign bus.o_TX_P_Data = txdata_q;
  assign bus.o_TX_D_VLD  = txvld_q;
  assign bus.o_Cmd_Err   = err_q;
  assign bus.o_Busy      = busy_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl with a behavioural register file (REG2=0x81, REG3=0x20 after reset).
module tb_sys_ctrl;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  sys_ctrl_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus ();

  sys_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RD_TIMEOUT(4)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.master)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // Register-file model: one-cycle read latency, reset by RSTn like the real block.
  logic [7:0] rf [16];
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic       rf_mute = 1'b0;
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      rf[2] <= 8'h81;
      rf[3] <= 8'h20;
      rf_rd_valid <= 1'b0;
      rf_rd_data  <= 8'h00;
    end else begin
      if (bus.o_WrEn) rf[bus.o_Address] <= bus.o_WrData;
      rf_rd_valid <= bus.o_RdEn && !rf_mute;
      if (bus.o_RdEn) rf_rd_data <= rf[bus.o_Address];
    end
  end
  assign bus.i_RdData       = rf_rd_data;
  assign bus.i_RdData_Valid = rf_rd_valid;

  // Monitor: counts strobes and remembers the last transaction seen.
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int overlap_cnt = 0, tx_wide = 0, err_wide = 0;
  logic [3:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0, last_tx = '0;
  logic prev_tx = 1'b0, prev_err = 1'b0;
  always @(negedge CLK) begin
    if (bus.o_WrEn) begin
      wr_cnt++;
      last_wr_addr = bus.o_Address;
      last_wr_data = bus.o_WrData;
    end
    if (bus.o_RdEn) rd_cnt++;
    if (bus.o_WrEn && bus.o_RdEn) overlap_cnt++;
    if (bus.o_TX_D_VLD) begin
      tx_cnt++;
      last_tx = bus.o_TX_P_Data;
      if (prev_tx) tx_wide++;
    end
    if (bus.o_Cmd_Err) begin
      err_cnt++;
      if (prev_err) err_wide++;
    end
    if (bus.o_Busy) busy_cnt++;
    prev_tx  = bus.o_TX_D_VLD;
    prev_err = bus.o_Cmd_Err;
  end

  // Driver tasks: every task starts and ends 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_P_Data = b;
    bus.i_RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    bus.i_RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input int start, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (tx_cnt != start) break;
      idle(1);
    end
  endtask

  task automatic test_reset;
    @(posedge CLK);
    #1;
    if ({bus.o_WrEn, bus.o_RdEn, bus.o_TX_D_VLD, bus.o_Cmd_Err, bus.o_Busy} !== 5'b0) begin
      $display("FAIL reset_strobes: got %b want 00000",
               {bus.o_WrEn, bus.o_RdEn, bus.o_TX_D_VLD, bus.o_Cmd_Err, bus.o_Busy});
      n_fail++;
    end
    n_cmp++;
    RSTn = 1'b1;
    idle(2);
    if ({bus.o_Address, bus.o_WrData, bus.o_TX_P_Data} !== 20'h0) begin
      $display("FAIL reset_data: got %h want 00000", {bus.o_Address, bus.o_WrData, bus.o_TX_P_Data});
      n_fail++;
    end
    n_cmp++;
    if (bus.dbg_state !== 3'd0) begin
      $display("FAIL reset_state: got %0d want 0", bus.dbg_state);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_write;
    int w0, t0;
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h5A);
    idle(3);
    if (wr_cnt - w0 !== 1) begin
      $display("FAIL write_count: got %0d want 1", wr_cnt - w0);
      n_fail++;
    end
    n_cmp++;
    if ({last_wr_addr, last_wr_data} !== 12'h15A) begin
      $display("FAIL write_fields: got %h want 15a", {last_wr_addr, last_wr_data});
      n_fail++;
    end
    n_cmp++;
    exp_q.push_back(8'h5A);
    t0 = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h01);
    wait_tx(t0, 20);
    if (tx_cnt - t0 !== 1 || last_tx !== exp_q.pop_front()) begin
      $display("FAIL write_readback: tx pulses %0d data %h want 1 pulse of 5a", tx_cnt - t0, last_tx);
      n_fail++;
    end
    n_cmp++;
    idle(2);
  endtask

  task automatic test_read_reg2;
    int r0, t0;
    r0 = rd_cnt;
    t0 = tx_cnt;
    exp_q.push_back(8'h81);
    send_byte(8'hBB);
    send_byte(8'h02);
    wait_tx(t0, 20);
    idle(2);
    if (rd_cnt - r0 !== 1) begin
      $display("FAIL read_rden_count: got %0d want 1", rd_cnt - r0);
      n_fail++;
    end
    n_cmp++;
    if (tx_cnt - t0 !== 1 || last_tx !== exp_q.pop_front()) begin
      $display("FAIL read_reg2: tx pulses %0d data %h want 1 pulse of 81", tx_cnt - t0, last_tx);
      n_fail++;
    end
    n_cmp++;
    if (bus.o_Busy !== 1'b0) begin
      $display("FAIL read_busy_after: got %b want 0", bus.o_Busy);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_busy_hold;
    int t0;
    logic [7:0] held;
    bus.i_TX_Busy = 1'b1;
    t0 = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h03);
    idle(2);
    held = bus.o_TX_P_Data;
    idle(18);
    if (tx_cnt !== t0 || bus.dbg_state !== 3'd5 || bus.o_TX_P_Data !== held) begin
      $display("FAIL busy_wait: tx pulses %0d state %0d data %h want 0 pulses state 5 data %h",
               tx_cnt - t0, bus.dbg_state, bus.o_TX_P_Data, held);
      n_fail++;
    end
    n_cmp++;
    bus.i_TX_Busy = 1'b0;
    @(negedge CLK);
    if (bus.o_TX_D_VLD !== 1'b0) begin
      $display("FAIL busy_release_early: got %b want 0", bus.o_TX_D_VLD);
      n_fail++;
    end
    n_cmp++;
    @(negedge CLK);
    if (bus.o_TX_D_VLD !== 1'b1 || bus.o_TX_P_Data !== 8'h20) begin
      $display("FAIL busy_release_send: vld %b data %h want 1 20", bus.o_TX_D_VLD, bus.o_TX_P_Data);
      n_fail++;
    end
    n_cmp++;
    @(posedge CLK);
    #1;
    idle(2);
  endtask

  task automatic test_bad_cmd;
    int e0, w0, r0, t0, b0, ew0;
    e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt; b0 = busy_cnt; ew0 = err_wide;
    send_byte(8'h33);
    if (bus.o_Cmd_Err !== 1'b1 || bus.o_Busy !== 1'b0) begin
      $display("FAIL bad_cmd_err: err %b busy %b want 1 0", bus.o_Cmd_Err, bus.o_Busy);
      n_fail++;
    end
    n_cmp++;
    idle(3);
    if (err_cnt - e0 !== 1 || err_wide !== ew0) begin
      $display("FAIL bad_cmd_pulse: errs %0d wide %0d want 1 0", err_cnt - e0, err_wide - ew0);
      n_fail++;
    end
    n_cmp++;
    if (wr_cnt !== w0 || rd_cnt !== r0 || tx_cnt !== t0 || busy_cnt !== b0) begin
      $display("FAIL bad_cmd_side: wr %0d rd %0d tx %0d busy %0d want all 0",
               wr_cnt - w0, rd_cnt - r0, tx_cnt - t0, busy_cnt - b0);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_rx_during_wait;
    int e0, t0;
    bus.i_TX_Busy = 1'b1;
    t0 = tx_cnt;
    exp_q.push_back(8'h81);
    send_byte(8'hBB);
    send_byte(8'h02);
    idle(4);
    e0 = err_cnt;
    send_byte(8'h44);
    idle(1);
    if (err_cnt - e0 !== 1 || bus.dbg_state !== 3'd5) begin
      $display("FAIL rx_in_txsend: errs %0d state %0d want 1 5", err_cnt - e0, bus.dbg_state);
      n_fail++;
    end
    n_cmp++;
    bus.i_TX_Busy = 1'b0;
    wait_tx(t0, 10);
    if (tx_cnt - t0 !== 1 || last_tx !== exp_q.pop_front()) begin
      $display("FAIL rx_in_txsend_data: tx pulses %0d data %h want 1 pulse of 81", tx_cnt - t0, last_tx);
      n_fail++;
    end
    n_cmp++;
    idle(2);
  endtask

  task automatic test_rd_timeout;
    int e0, t0;
    rf_mute = 1'b1;
    e0 = err_cnt;
    t0 = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h05);
    if (bus.dbg_state !== 3'd4) begin
      $display("FAIL rd_wait_enter: got state %0d want 4", bus.dbg_state);
      n_fail++;
    end
    n_cmp++;
    idle(8);
    if (err_cnt - e0 !== 1 || tx_cnt !== t0 || bus.dbg_state !== 3'd0 || bus.o_Busy !== 1'b0) begin
      $display("FAIL rd_timeout: errs %0d tx %0d state %0d busy %b want 1 0 0 0",
               err_cnt - e0, tx_cnt - t0, bus.dbg_state, bus.o_Busy);
      n_fail++;
    end
    n_cmp++;
    rf_mute = 1'b0;
  endtask

  task automatic test_back_to_back;
    int w0, r0, t0;
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
    exp_q.push_back(8'h66);
    send_byte(8'hAA);
    send_byte(8'h04);
    send_byte(8'h66);
    send_byte(8'hBB);
    send_byte(8'h04);
    wait_tx(t0, 20);
    if (wr_cnt - w0 !== 1 || {last_wr_addr, last_wr_data} !== 12'h466) begin
      $display("FAIL b2b_write: writes %0d fields %h want 1 466", wr_cnt - w0, {last_wr_addr, last_wr_data});
      n_fail++;
    end
    n_cmp++;
    if (rd_cnt - r0 !== 1 || tx_cnt - t0 !== 1 || last_tx !== exp_q.pop_front()) begin
      $display("FAIL b2b_read: reads %0d tx %0d data %h want 1 1 66", rd_cnt - r0, tx_cnt - t0, last_tx);
      n_fail++;
    end
    n_cmp++;
    idle(2);
  endtask

  task automatic test_reset_midcmd;
    int w0, t0;
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h00);
    idle(1);
    if (bus.dbg_state !== 3'd2 || bus.o_Busy !== 1'b1) begin
      $display("FAIL midcmd_state: state %0d busy %b want 2 1", bus.dbg_state, bus.o_Busy);
      n_fail++;
    end
    n_cmp++;
    #2;
    RSTn = 1'b0;
    #1;
    if (bus.dbg_state !== 3'd0 || bus.o_Busy !== 1'b0 || bus.o_WrData !== 8'h00 || bus.o_Address !== 4'h0) begin
      $display("FAIL async_reset: state %0d busy %b wrdata %h addr %h want 0 0 00 0",
               bus.dbg_state, bus.o_Busy, bus.o_WrData, bus.o_Address);
      n_fail++;
    end
    n_cmp++;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    idle(1);
    if (wr_cnt !== w0) begin
      $display("FAIL midcmd_no_write: writes %0d want 0", wr_cnt - w0);
      n_fail++;
    end
    n_cmp++;
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(2);
    if (wr_cnt - w0 !== 1 || {last_wr_addr, last_wr_data} !== 12'h011) begin
      $display("FAIL midcmd_rewrite: writes %0d fields %h want 1 011", wr_cnt - w0, {last_wr_addr, last_wr_data});
      n_fail++;
    end
    n_cmp++;
    t0 = tx_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'hBB);
    send_byte(8'h00);
    wait_tx(t0, 20);
    if (tx_cnt - t0 !== 1 || last_tx !== exp_q.pop_front()) begin
      $display("FAIL midcmd_reg0: tx pulses %0d data %h want 1 pulse of 11", tx_cnt - t0, last_tx);
      n_fail++;
    end
    n_cmp++;
    idle(2);
  endtask

`ifdef SYS_CTRL_FRAME_TIMEOUT_EN
  task automatic test_partial_cmd;
    int e0, w0;
    e0 = err_cnt;
    send_byte(8'hBB);
    idle(1000);
    if (err_cnt !== e0 || bus.dbg_state !== 3'd3) begin
      $display("FAIL frame_early: errs %0d state %0d want 0 3", err_cnt - e0, bus.dbg_state);
      n_fail++;
    end
    n_cmp++;
    idle(40);
    if (err_cnt - e0 !== 1 || bus.dbg_state !== 3'd0 || bus.o_Busy !== 1'b0) begin
      $display("FAIL frame_timeout: errs %0d state %0d busy %b want 1 0 0",
               err_cnt - e0, bus.dbg_state, bus.o_Busy);
      n_fail++;
    end
    n_cmp++;
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h22);
    idle(2);
    if (wr_cnt - w0 !== 1 || {last_wr_addr, last_wr_data} !== 12'h022) begin
      $display("FAIL frame_recover: writes %0d fields %h want 1 022", wr_cnt - w0, {last_wr_addr, last_wr_data});
      n_fail++;
    end
    n_cmp++;
  endtask
`else
  task automatic test_partial_cmd;
    int e0, t0;
    e0 = err_cnt;
    t0 = tx_cnt;
    exp_q.push_back(8'h81);
    send_byte(8'hBB);
    idle(50);
    if (err_cnt !== e0 || bus.dbg_state !== 3'd3 || bus.o_Busy !== 1'b1) begin
      $display("FAIL partial_wait: errs %0d state %0d busy %b want 0 3 1",
               err_cnt - e0, bus.dbg_state, bus.o_Busy);
      n_fail++;
    end
    n_cmp++;
    send_byte(8'h02);
    wait_tx(t0, 20);
    if (tx_cnt - t0 !== 1 || last_tx !== exp_q.pop_front()) begin
      $display("FAIL partial_finish: tx pulses %0d data %h want 1 pulse of 81", tx_cnt - t0, last_tx);
      n_fail++;
    end
    n_cmp++;
  endtask
`endif

  initial begin
    bus.i_RX_P_Data = 8'h00;
    bus.i_RX_D_VLD  = 1'b0;
    bus.i_TX_Busy   = 1'b0;
    test_reset();
    test_write();
    test_read_reg2();
    test_busy_hold();
    test_bad_cmd();
    test_rx_during_wait();
    test_rd_timeout();
    test_back_to_back();
    test_reset_midcmd();
    test_partial_cmd();
    idle(3);
    if (overlap_cnt !== 0 || tx_wide !== 0) begin
      $display("FAIL strobe_rules: wr/rd overlap %0d tx wide %0d want 0 0", overlap_cnt, tx_wide);
      n_fail++;
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

- Command controller between the UART receiver and the register file.
- Decodes byte streams from the RX data path into register-file write and read transactions.
- Returns each read result to the UART transmitter through a valid/busy handshake.
- One instance per UART system; drives the register file's write/read port, which in turn holds frame configuration (REG2 = 0x81, REG3 = 0x20 after reset).

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of RX/TX data and register data
- ADDRESS_WIDTH, 4, register-file address width; the command address byte is truncated to its low ADDRESS_WIDTH bits
- RD_TIMEOUT, 4, cycles to wait for i_RdData_Valid after a read request

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- i_RX_P_Data  in  DATA_WIDTH  received byte
- i_RX_D_VLD  in  1  one-cycle pulse, i_RX_P_Data valid
- i_RdData  in  DATA_WIDTH  register-file read data
- i_RdData_Valid  in  1  register-file read data valid
- i_TX_Busy  in  1  transmitter busy, TX byte cannot be accepted
- o_Address  out  ADDRESS_WIDTH  register-file address
- o_WrData  out  DATA_WIDTH  register-file write data
- o_WrEn  out  1  register-file write strobe, one cycle
- o_RdEn  out  1  register-file read strobe, one cycle
- o_TX_P_Data  out  DATA_WIDTH  byte to transmit
- o_TX_D_VLD  out  1  one-cycle pulse, o_TX_P_Data valid
- o_Cmd_Err  out  1  one-cycle pulse on protocol error
- o_Busy  out  1  high whenever state ≠ IDLE

## Operation
- Commands:
  - 0xAA, ADDR, DATA → register write
  - 0xBB, ADDR → register read, result transmitted
- Any other first byte: dropped, o_Cmd_Err pulses, state stays IDLE.
- States and transitions:
  - IDLE: 0xAA → WR_ADDR; 0xBB → RD_ADDR
  - WR_ADDR: byte latched into o_Address → WR_DATA
  - WR_DATA: byte latched into o_WrData, o_WrEn = 1 next cycle → IDLE
  - RD_ADDR: byte latched into o_Address, o_RdEn = 1 next cycle → RD_WAIT
  - RD_WAIT: on i_RdData_Valid, capture i_RdData into the hold register → TX_SEND; if RD_TIMEOUT cycles elapse without it, o_Cmd_Err pulses → IDLE
  - TX_SEND: when i_TX_Busy = 0, o_TX_D_VLD = 1 for one cycle with o_TX_P_Data = hold register → IDLE
- RX bytes arriving in RD_WAIT or TX_SEND: dropped, o_Cmd_Err pulses, state unchanged.
- All outputs are registered. o_Address and o_WrData hold their last value between commands.
- Reset (asserted asynchronously at any time, including mid-command): all outputs 0, state IDLE, hold register 0, timers 0. A partial command is discarded; no write strobe is issued.

## Timing
- RX pulse sampled at edge N → state/latch update at edge N; strobes are high during cycle N+1 only.
- Write latency: last byte valid at edge N → o_WrEn high N+1 → register updated at edge N+2.
- Read: o_RdEn high N+1 → i_RdData_Valid expected by edge N+2 (register-file latency is one cycle).
- TX: o_TX_D_VLD rises the cycle after the capture edge if i_TX_Busy = 0; otherwise it waits with o_TX_P_Data stable.
- Back-to-back commands: a new 0xAA/0xBB may arrive in the cycle o_WrEn is high; it is accepted.
- o_WrEn and o_RdEn are never high together.

## Configuration
- SYS_CTRL_FRAME_TIMEOUT_EN defined:
  - inter-byte counter active in WR_ADDR, WR_DATA and RD_ADDR
  - if 1024 cycles pass without i_RX_D_VLD: o_Cmd_Err pulses, state → IDLE, no strobe issued
- Macro undefined:
  - counter not present
  - partial commands wait indefinitely
  - RD_WAIT timeout is unaffected in both builds

## Test plan
- Reset, then bytes 0xAA, 0x01, 0x5A → single o_WrEn pulse with o_Address = 1, o_WrData = 0x5A; REG1 reads back 0x5A.
- Bytes 0xBB, 0x02 with i_TX_Busy = 0 → o_RdEn pulse, then o_TX_D_VLD pulse with o_TX_P_Data = 0x81 (reset value of REG2).
- Read of address 3 with i_TX_Busy held high 20 cycles → o_TX_D_VLD waits, then pulses with 0x20 the cycle after i_TX_Busy falls.
- Byte 0x33 in IDLE → o_Cmd_Err one-cycle pulse, no strobes, o_Busy stays 0.
- 0xAA, 0x00 then RSTn low for 2 cycles, then 0xAA, 0x00, 0x11 → no write before reset; REG0 = 0x11 after the second command.
- With SYS_CTRL_FRAME_TIMEOUT_EN: 0xBB followed by 1024 idle cycles → o_Cmd_Err pulse, state IDLE; a following 0xAA, 0x00, 0x22 writes normally.
